// File: rtl/lab3_defs.sv
// Shared defaults and direction encoding for the button front-end and LED rotator.
package lab3_defs;

    localparam int unsigned SAMPLE_W_DEF     = 17;
    localparam int unsigned DB_LEN_DEF       = 4;
    localparam int unsigned LONG_SAMPLES_DEF = 1024;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // One bit per button, used for level and press buses inside button_ctrl.
    typedef struct packed {
        logic en;
        logic dir;
    } btn_pair_t;

endpackage

// File: rtl/button_ctrl_debounce_onepulse.sv
// Per-button path: two-flop synchroniser, tick-sampled debounce shift register, rising-edge pulse.
module debounce_onepulse
    import lab3_defs::*;
#(
    parameter int unsigned DB_LEN = DB_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic tick,
    output logic level,
    output logic press,
    output logic press_c
);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [DB_LEN-1:0] shift_q, shift_d;
    logic              level_q, level_d;
    logic              press_q, press_d;

    // Level follows a full run of equal samples; press_d lets the owner act in the pulse cycle.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        shift_d = shift_q;
        if (tick) begin
            shift_d = {shift_q[DB_LEN-2:0], sync2_q};
        end
        level_d = level_q;
        if (&shift_d) begin
            level_d = 1'b1;
        end else if (~|shift_d) begin
            level_d = 1'b0;
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            shift_q <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            shift_q <= shift_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level   = level_q;
    assign press   = press_q;
    assign press_c = press_d;

endmodule

// File: rtl/button_ctrl.sv
// Button front-end: prescaled debounce of btn_en/btn_dir into toggled en/dir levels.
// Define BUTTON_CTRL_LONG_PRESS_EN to add the btn_en long-press rst_req pulse.
module button_ctrl
    import lab3_defs::*;
#(
    parameter int unsigned SAMPLE_W     = SAMPLE_W_DEF,
    parameter int unsigned DB_LEN       = DB_LEN_DEF,
    parameter int unsigned LONG_SAMPLES = LONG_SAMPLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_en,
    input  logic btn_dir,
    output logic en,
    output logic dir,
    output logic press_en,
    output logic press_dir,
    output logic rst_req
);

    logic [SAMPLE_W-1:0] cnt_q, cnt_d;
    logic                tick_c;
    btn_pair_t           level, press, press_c;
    logic                en_q, en_d;
    logic                dir_q, dir_d;

    assign tick_c = &cnt_q;

    debounce_onepulse #(.DB_LEN(DB_LEN)) u_db_en (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_en),
        .tick    (tick_c),
        .level   (level.en),
        .press   (press.en),
        .press_c (press_c.en)
    );

    debounce_onepulse #(.DB_LEN(DB_LEN)) u_db_dir (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_dir),
        .tick    (tick_c),
        .level   (level.dir),
        .press   (press.dir),
        .press_c (press_c.dir)
    );

`ifdef BUTTON_CTRL_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_SAMPLES) + 1;

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rst_req_q, rst_req_d;
`endif

    always_comb begin
        cnt_d = cnt_q + SAMPLE_W'(1);
        en_d  = en_q ^ press_c.en;
        dir_d = dir_q ^ press_c.dir;
`ifdef BUTTON_CTRL_LONG_PRESS_EN
        hold_d    = hold_q;
        rst_req_d = 1'b0;
        if (!level.en) begin
            hold_d = '0;
        end else if (tick_c && (hold_q != HOLD_W'(LONG_SAMPLES))) begin
            hold_d = hold_q + HOLD_W'(1);
        end
        // Fires only on the step into saturation, so one request per hold.
        if ((hold_d == HOLD_W'(LONG_SAMPLES)) && (hold_q != HOLD_W'(LONG_SAMPLES))) begin
            rst_req_d = 1'b1;
            en_d      = 1'b0;
            dir_d     = DIR_RIGHT;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
            dir_q <= DIR_RIGHT;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
            dir_q <= dir_d;
        end
    end

`ifdef BUTTON_CTRL_LONG_PRESS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            rst_req_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            rst_req_q <= rst_req_d;
        end
    end

    assign rst_req = rst_req_q;
`else
    assign rst_req = 1'b0;
`endif

    assign en        = en_q;
    assign dir       = dir_q;
    assign press_en  = press.en;
    assign press_dir = press.dir;

endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl with SAMPLE_W=4, DB_LEN=4, LONG_SAMPLES=8 (tick every 16 clk).
module tb_button_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_en = 1'b0;
    logic btn_dir = 1'b0;
    logic en, dir, press_en, press_dir, rst_req;

    int n_cmp = 0;
    int n_bad = 0;

    int pe_tot = 0, pd_tot = 0, both_tot = 0, rr_tot = 0, wide_tot = 0;
    logic pe_prev = 1'b0, pd_prev = 1'b0, rr_prev = 1'b0;

    typedef struct {
        logic en_in;
        logic dir_in;
        logic bounce;
        int   cycles;
        logic exp_en;
        logic exp_dir;
        int   exp_pe;
        int   exp_pd;
        int   exp_both;
    } vec_t;

    vec_t vecs[9];

    button_ctrl #(.SAMPLE_W(4), .DB_LEN(4), .LONG_SAMPLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_en    (btn_en),
        .btn_dir   (btn_dir),
        .en        (en),
        .dir       (dir),
        .press_en  (press_en),
        .press_dir (press_dir),
        .rst_req   (rst_req)
    );

    always #5 clk = ~clk;

    // Pulse counting and width tracking, sampled mid-cycle.
    always @(negedge clk) begin
        if (press_en)              pe_tot   <= pe_tot + 1;
        if (press_dir)             pd_tot   <= pd_tot + 1;
        if (press_en && press_dir) both_tot <= both_tot + 1;
        if (rst_req)               rr_tot   <= rr_tot + 1;
        if ((press_en && pe_prev) || (press_dir && pd_prev) || (rst_req && rr_prev))
            wide_tot <= wide_tot + 1;
        pe_prev <= press_en;
        pd_prev <= press_dir;
        rr_prev <= rst_req;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Leaves the bench one step into cycle 0 after a one-clock reset.
    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        int pe0, pd0, both0, rr0;
        logic exp_long;
`ifdef BUTTON_CTRL_LONG_PRESS_EN
        exp_long = 1'b1;
`else
        exp_long = 1'b0;
`endif

        vecs[0] = '{1'b0, 1'b0, 1'b0, 200, 1'b0, 1'b0, 0, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 100, 1'b1, 1'b0, 1, 0, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 100, 1'b1, 1'b0, 0, 0, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 300, 1'b1, 1'b0, 0, 0, 0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 100, 1'b1, 1'b1, 0, 1, 0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 100, 1'b1, 1'b1, 0, 0, 0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 100, 1'b0, 1'b0, 1, 1, 1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 100, 1'b0, 1'b0, 0, 0, 0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 100, 1'b1, 1'b1, 1, 1, 1};

        step(2);
        do_reset();
        chk("rst en", int'(en), 0);
        chk("rst dir", int'(dir), 0);
        chk("rst press_en", int'(press_en), 0);
        chk("rst press_dir", int'(press_dir), 0);
        chk("rst rst_req", int'(rst_req), 0);

        // Exact latency: btn_en raised in cycle 20, 4th tick at cycle 79, pulse in cycle 80.
        step(20);
        btn_en = 1'b1;
        pe0 = pe_tot;
        step(59);
        chk("lat c79 press_en", int'(press_en), 0);
        chk("lat c79 en", int'(en), 0);
        step(1);
        chk("lat c80 press_en", int'(press_en), 1);
        chk("lat c80 en", int'(en), 1);
        step(1);
        chk("lat c81 press_en", int'(press_en), 0);
        chk("lat c81 en", int'(en), 1);
        step(19);
        chk("lat pulse count", pe_tot - pe0, 1);

        // Reset while held: re-press after 4 ticks (cycle 64), then long press at tick 12 (cycle 192).
        do_reset();
        chk("midrst en", int'(en), 0);
        chk("midrst press_en", int'(press_en), 0);
        pe0 = pe_tot;
        rr0 = rr_tot;
        step(63);
        chk("midrst c63 press_en", int'(press_en), 0);
        chk("midrst c63 en", int'(en), 0);
        step(1);
        chk("midrst c64 press_en", int'(press_en), 1);
        chk("midrst c64 en", int'(en), 1);
        step(6);
        btn_dir = 1'b1;
        step(58);
        chk("hold c128 press_dir", int'(press_dir), 1);
        chk("hold c128 dir", int'(dir), 1);
        step(63);
        chk("hold c191 rst_req", int'(rst_req), 0);
        chk("hold c191 en", int'(en), 1);
        step(1);
        chk("hold c192 rst_req", int'(rst_req), int'(exp_long));
        chk("hold c192 en", int'(en), int'(!exp_long));
        chk("hold c192 dir", int'(dir), int'(!exp_long));
        step(1);
        chk("hold c193 rst_req", int'(rst_req), 0);
        step(200);
        chk("hold rst_req count", rr_tot - rr0, int'(exp_long));
        chk("hold press_en count", pe_tot - pe0, 1);
        chk("hold end en", int'(en), int'(!exp_long));

        btn_en  = 1'b0;
        btn_dir = 1'b0;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            btn_en  = vecs[i].en_in;
            btn_dir = vecs[i].dir_in;
            pe0   = pe_tot;
            pd0   = pd_tot;
            both0 = both_tot;
            rr0   = rr_tot;
            for (int k = 0; k < vecs[i].cycles; k++) begin
                if (vecs[i].bounce) btn_dir = ((k / 10) % 2) == 0;
                step(1);
            end
            chk($sformatf("row%0d en", i), int'(en), int'(vecs[i].exp_en));
            chk($sformatf("row%0d dir", i), int'(dir), int'(vecs[i].exp_dir));
            chk($sformatf("row%0d press_en count", i), pe_tot - pe0, vecs[i].exp_pe);
            chk($sformatf("row%0d press_dir count", i), pd_tot - pd0, vecs[i].exp_pd);
            chk($sformatf("row%0d same-cycle presses", i), both_tot - both0, vecs[i].exp_both);
            chk($sformatf("row%0d rst_req count", i), rr_tot - rr0, 0);
        end

        chk("pulse width >1 clk", wide_tot, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
